conv_tile_sequencer: RTL
========================

# conv_tile_sequencer

Upstream controller for `CONV_256PE`. It walks one convolution layer tile by tile, fetching im2col IFM words and weights from two synchronous-read memories. For each tile it drives `IFM`, `Weight`, `PE_en` and `PE_finish` into the PE array, then hands each finished 256-lane OFM tile to the downstream writeback with a capture strobe. This replaces the hand-timed PE_en/PE_finish stimulus with a cycle-exact hardware sequence.

## Interface
- `NUM_OF_PE`, 256, PE lanes per tile
- `DATA_W`, 8, bits per lane/weight
- `KERNEL_PIXELS`, 9, 3x3 kernel taps per channel
- `IN_CHANNELS`, 3, input channels accumulated per tile
- `NUM_TILES`, 4, tiles per layer (1024 pixels / 256)
- `IFM_AW`, 7, IFM memory address width (≥ clog2(IN_CHANNELS·NUM_TILES·KERNEL_PIXELS))
- `W_AW`, 5, weight memory address width (≥ clog2(IN_CHANNELS·KERNEL_PIXELS))

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request, accepted only in IDLE
- `busy` out 1: high from the cycle after start accept until done
- `done` out 1: one-cycle pulse after the last tile is captured
- `ifm_addr` out IFM_AW: IFM memory word address
- `ifm_rdata` in NUM_OF_PE·DATA_W: IFM word, valid 1 cycle after address
- `w_addr` out W_AW: weight memory address
- `w_rdata` in DATA_W: weight, valid 1 cycle after address
- `IFM` out NUM_OF_PE·DATA_W: to PE array, flow-through of `ifm_rdata`, gated to 0 when not streaming
- `Weight` out DATA_W: to PE array, flow-through of `w_rdata`, gated to 0 when not streaming
- `PE_en` out NUM_OF_PE: all-ones for one cycle at tile start
- `PE_finish` out NUM_OF_PE: all-ones for one cycle after the last MAC step
- `valid` in NUM_OF_PE: PE result valid; only bit 0 is examined
- `ofm_ready` in 1: downstream can accept a tile
- `ofm_capture` out 1: one-cycle strobe; OFM is valid and accepted this cycle
- `ofm_tile` out clog2(NUM_TILES): tile index accompanying `ofm_capture`

## Operation
- STEPS = KERNEL_PIXELS·IN_CHANNELS (27). Step s maps to pixel p = s mod KERNEL_PIXELS and channel c = s / KERNEL_PIXELS.
- Address map:
  - `ifm_addr` = (c·NUM_TILES + tile)·KERNEL_PIXELS + p
  - `w_addr` = c·KERNEL_PIXELS + p
  - Weights are shared by all tiles.
- FSM states: IDLE, EN, STREAM, FINISH, CAPTURE, DONE.
- IDLE → EN on `start`. Tile and step counters clear.
- EN (1 cycle):
  - `PE_en` is all-ones.
  - Addresses for step 0 are issued.
  - → STREAM.
- STREAM (STEPS cycles):
  - Each cycle presents data for step s on `IFM`/`Weight` and issues the addresses for step s+1.
  - When the presented step is STEPS−1 → FINISH.
- FINISH (1 cycle): `PE_finish` is all-ones; `IFM`/`Weight` are 0. → CAPTURE.
- CAPTURE:
  - Waits for `valid[0]` && `ofm_ready`. In that cycle `ofm_capture`=1 and `ofm_tile`=tile.
  - Then → EN with tile+1, or → DONE if tile == NUM_TILES−1.
- DONE (1 cycle): `done`=1. → IDLE.
- `start` outside IDLE is ignored.
- Counters saturate-free: step counter width is clog2(STEPS+1), tile counter width is clog2(NUM_TILES).
- Addresses are computed with unsigned arithmetic, no wrap within a layer.

## Timing
- Reset: FSM=IDLE. All outputs are 0 (`busy`, `done`, `PE_en`, `PE_finish`, `ofm_capture`, `ofm_tile`, `ifm_addr`, `w_addr`, `IFM`, `Weight`).
- Reset asserted mid-tile aborts immediately. No `PE_finish` or `ofm_capture` follows.
- Per tile, with E = the EN cycle:
  - `PE_en` at E
  - step s on `IFM`/`Weight` at E+1+s
  - `PE_finish` at E+STEPS+1 (E+28)
  - earliest `ofm_capture` at E+STEPS+2
  - next tile's EN the cycle after capture
- Minimum per-tile period is STEPS+3 = 30 cycles. Minimum layer time is NUM_TILES·30 + 2 cycles (start to `done`).
- `valid[0]` and `ofm_ready` both high in the same cycle completes the capture. `valid[0]` without `ofm_ready` holds CAPTURE indefinitely.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Structure
- Shared package `conv_pkg`:
  - state enum `seq_state_t` (IDLE..DONE)
  - localparam STEPS
  - defaults for NUM_OF_PE/DATA_W/KERNEL_PIXELS/IN_CHANNELS
- One sub-module `conv_addr_gen`: step/tile counters in, `ifm_addr`/`w_addr`/last-step flag out, purely registered.
- Top holds the FSM and output gating.

## Test plan
- Reset then `start`, memories preloaded with `ifm_word[a]` all lanes = a, weight[a] = a:
  - `PE_en` at E
  - `Weight` 0..26 at E+1..E+27
  - lane 0 of `IFM` = 0,1,..,8,36,..,44,72,..,80 for tile 0
  - `PE_finish` at E+28
- Full layer with `valid` tied high and `ofm_ready` high → four `ofm_capture` pulses with `ofm_tile` 0,1,2,3, 30 cycles apart; `done` at cycle 122 after start accept.
- `ofm_ready` low for 10 cycles during tile 1 CAPTURE → capture delayed exactly 10 cycles; no extra `PE_en`; `IFM`/`Weight` held at 0.
- `start` pulsed during STREAM → ignored; step/address sequence unchanged; still exactly four tiles.
- `reset_n` dropped at E+15 of tile 2 → all outputs 0 asynchronously; after release, FSM is IDLE; a new `start` begins at tile 0.
- `valid[0]` asserted early (during STREAM) → ignored; capture only occurs after FINISH.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution tile sequencer.
// Layer shape: 3x3 kernel, 3 channels, 4 tiles of 256 lanes.
package conv_pkg;

  localparam int NUM_OF_PE_D     = 256;
  localparam int DATA_W_D        = 8;
  localparam int KERNEL_PIXELS_D = 9;
  localparam int IN_CHANNELS_D   = 3;
  localparam int NUM_TILES_D     = 4;
  localparam int IFM_AW_D        = 7;
  localparam int W_AW_D          = 5;

  localparam int STEPS = KERNEL_PIXELS_D * IN_CHANNELS_D;

  typedef enum logic [2:0] {
    IDLE,
    EN,
    STREAM,
    FINISH,
    CAPTURE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Registered IFM/weight address generator for one MAC step.
// last_o marks the cycle in which the final step's data is presented.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int KERNEL_PIXELS = KERNEL_PIXELS_D,
  parameter int IN_CHANNELS   = IN_CHANNELS_D,
  parameter int NUM_TILES     = NUM_TILES_D,
  parameter int SW            = 5,
  parameter int TW            = 2,
  parameter int IFM_AW        = IFM_AW_D,
  parameter int W_AW          = W_AW_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_i,
  input  logic [SW-1:0]     step_i,
  input  logic [TW-1:0]     tile_i,
  output logic [IFM_AW-1:0] ifm_addr_o,
  output logic [W_AW-1:0]   w_addr_o,
  output logic              last_o
);

  localparam int ST = KERNEL_PIXELS * IN_CHANNELS;

  logic [IFM_AW-1:0] ifm_addr_q, ifm_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic              hold_q, last_q;
  int                ch, px;

  // Map step/tile to channel-major im2col word and shared weight.
  always_comb begin
    ch         = 0;
    px         = 0;
    ifm_addr_d = '0;
    w_addr_d   = '0;
    if (issue_i) begin
      ch = int'(step_i) / KERNEL_PIXELS;
      px = int'(step_i) % KERNEL_PIXELS;
      ifm_addr_d = IFM_AW'(
        (ch * NUM_TILES + int'(tile_i)) * KERNEL_PIXELS + px);
      w_addr_d = W_AW'(ch * KERNEL_PIXELS + px);
    end
  end

  // Address registers; last flag trails the final address by the
  // one-cycle memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifm_addr_q <= '0;
      w_addr_q   <= '0;
      hold_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      ifm_addr_q <= ifm_addr_d;
      w_addr_q   <= w_addr_d;
      hold_q     <= issue_i && (step_i == SW'(ST - 1));
      last_q     <= hold_q;
    end
  end

  assign ifm_addr_o = ifm_addr_q;
  assign w_addr_o   = w_addr_q;
  assign last_o     = last_q;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Tile-by-tile sequencer feeding the 256-PE convolution array.
// Drives PE_en/PE_finish, streams IFM/weights, hands off OFM tiles.
module conv_tile_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_OF_PE     = NUM_OF_PE_D,
  parameter int DATA_W        = DATA_W_D,
  parameter int KERNEL_PIXELS = KERNEL_PIXELS_D,
  parameter int IN_CHANNELS   = IN_CHANNELS_D,
  parameter int NUM_TILES     = NUM_TILES_D,
  parameter int IFM_AW        = IFM_AW_D,
  parameter int W_AW          = W_AW_D,
  localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [IFM_AW-1:0]           ifm_addr,
  input  logic [NUM_OF_PE*DATA_W-1:0] ifm_rdata,
  output logic [W_AW-1:0]             w_addr,
  input  logic [DATA_W-1:0]           w_rdata,
  output logic [NUM_OF_PE*DATA_W-1:0] IFM,
  output logic [DATA_W-1:0]           Weight,
  output logic [NUM_OF_PE-1:0]        PE_en,
  output logic [NUM_OF_PE-1:0]        PE_finish,
  input  logic [NUM_OF_PE-1:0]        valid,
  input  logic                        ofm_ready,
  output logic                        ofm_capture,
  output logic [TW-1:0]               ofm_tile
);

  localparam int ST = KERNEL_PIXELS * IN_CHANNELS;
  localparam int SW = $clog2(ST + 1);

  seq_state_t    state_q;
  logic [SW-1:0] step_q;
  logic [TW-1:0] tile_q;

  logic          iss_d;
  logic [SW-1:0] istep_d;
  logic [TW-1:0] itile_d;
  logic          last;
  logic          accept;
  logic          last_tile;
  logic          unused_valid;

  assign unused_valid = ^valid[NUM_OF_PE-1:1];

  assign accept    = (state_q == CAPTURE) && valid[0] && ofm_ready;
  assign last_tile = (tile_q == TW'(NUM_TILES - 1));

  // Address issue runs one step ahead of the data being presented.
  always_comb begin
    iss_d   = 1'b0;
    istep_d = '0;
    itile_d = tile_q;
    unique case (state_q)
      IDLE: begin
        iss_d   = start;
        itile_d = '0;
      end
      EN: begin
        iss_d   = 1'b1;
        istep_d = SW'(1);
      end
      STREAM: begin
        iss_d   = (step_q < SW'(ST - 2));
        istep_d = step_q + SW'(2);
      end
      CAPTURE: begin
        iss_d   = accept && !last_tile;
        itile_d = tile_q + TW'(1);
      end
      default: ;
    endcase
  end

  conv_addr_gen #(
    .KERNEL_PIXELS (KERNEL_PIXELS),
    .IN_CHANNELS   (IN_CHANNELS),
    .NUM_TILES     (NUM_TILES),
    .SW            (SW),
    .TW            (TW),
    .IFM_AW        (IFM_AW),
    .W_AW          (W_AW)
  ) u_addr (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue_i    (iss_d),
    .step_i     (istep_d),
    .tile_i     (itile_d),
    .ifm_addr_o (ifm_addr),
    .w_addr_o   (w_addr),
    .last_o     (last)
  );

  // Tile sequencing FSM with step and tile counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      tile_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= EN;
          step_q  <= '0;
          tile_q  <= '0;
        end
        EN: begin
          state_q <= STREAM;
          step_q  <= '0;
        end
        STREAM: begin
          if (last) state_q <= FINISH;
          else      step_q  <= step_q + SW'(1);
        end
        FINISH: state_q <= CAPTURE;
        CAPTURE: if (accept) begin
          if (last_tile) begin
            state_q <= DONE;
          end else begin
            tile_q  <= tile_q + TW'(1);
            state_q <= EN;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign PE_en       = {NUM_OF_PE{state_q == EN}};
  assign PE_finish   = {NUM_OF_PE{state_q == FINISH}};
  assign IFM         = (state_q == STREAM) ? ifm_rdata : '0;
  assign Weight      = (state_q == STREAM) ? w_rdata : '0;
  assign ofm_capture = accept;
  assign ofm_tile    = accept ? tile_q : '0;

endmodule
